// File: rtl/ordered_undithering_if.sv
// Stream bundle for ordered_undithering: 16-bit dithered input words in,
// 32-bit reconstructed grey words out, valid/ready on both sides.
interface ordered_undithering_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_sof;
    logic        s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    modport slave (
        input  s_valid, s_data, s_sof, s_eol, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_sof, s_eol, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/ordered_undithering.sv
// Inverse of the 4-bit ordered-dither quantiser: per-lane threshold removal and clamp to 8 bits.
// Define UNDITHER_SATCOUNT_EN to add the saturating clamp counter output sat_count.
module ordered_undithering #(
    parameter string COLORMODE = "DES",
    parameter int    BIAS      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [6:0]  cfg_addr,
    input  logic [3:0]  cfg_wdata,
`ifdef UNDITHER_SATCOUNT_EN
    output logic [15:0] sat_count,
`endif
    ordered_undithering_if.slave bus
);

    localparam bit          IS_MONO = (COLORMODE == "MONO");
    localparam int unsigned XPER    = IS_MONO ? 1 : 3;
    localparam int unsigned YPER    = IS_MONO ? 4 : 6;
    localparam int unsigned DEPTH   = XPER * YPER * 4;
    localparam int unsigned IDXW    = $clog2(DEPTH);

    localparam logic [1:0]        XPER_L = 2'(XPER);
    localparam logic [2:0]        YPER_L = 3'(YPER);
    localparam logic signed [9:0] OFFSET = 10'(8 - BIAS);

    function automatic logic [IDXW-1:0] tbl_index(input logic [2:0] y,
                                                  input logic [1:0] x,
                                                  input logic [1:0] lane);
        return IDXW'((32'(y) * XPER + 32'(x)) * 4 + 32'(lane));
    endfunction

    logic [3:0] tbl [DEPTH];
    logic [1:0] x_cnt;
    logic [2:0] y_cnt;

    logic       accept;
    logic [1:0] x_use;
    logic [2:0] y_use;
    logic [1:0] x_next;
    logic [2:0] y_next;

    assign bus.s_ready = !bus.m_valid || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;

    // A start-of-frame beat is pinned to the pattern origin regardless of the counters.
    assign x_use  = bus.s_sof ? '0 : x_cnt;
    assign y_use  = bus.s_sof ? '0 : y_cnt;
    assign x_next = (x_use == XPER_L - 2'd1) ? '0 : x_use + 2'd1;
    assign y_next = (y_use == YPER_L - 3'd1) ? '0 : y_use + 3'd1;

    logic [2:0] cfg_y;
    logic [1:0] cfg_x;
    logic [1:0] cfg_lane;
    logic       cfg_ok;

    assign cfg_y    = cfg_addr[6:4];
    assign cfg_x    = cfg_addr[3:2];
    assign cfg_lane = cfg_addr[1:0];
    assign cfg_ok   = cfg_we && (cfg_y < YPER_L) && (cfg_x < XPER_L);

    logic [31:0]       pix_word;
    logic [2:0]        clamp_cnt;
    logic [3:0]        nib;
    logic [3:0]        ent;
    logic signed [9:0] diff;
    logic signed [9:0] p;
    logic [7:0]        lane_val;

    always_comb begin
        pix_word  = '0;
        clamp_cnt = '0;
        nib       = '0;
        ent       = '0;
        diff      = '0;
        p         = '0;
        lane_val  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            nib  = bus.s_data[15 - 4*i -: 4];
            ent  = tbl[tbl_index(y_use, x_use, 2'(i))];
            diff = {6'b0, nib} - {{6{ent[3]}}, ent};
            p    = (diff <<< 4) + OFFSET;
            // Sign bit marks underflow; bit 8 on a non-negative value marks >255.
            if (p[9]) begin
                lane_val  = '0;
                clamp_cnt = clamp_cnt + 3'd1;
            end else if (p[8]) begin
                lane_val  = '1;
                clamp_cnt = clamp_cnt + 3'd1;
            end else begin
                lane_val  = p[7:0];
            end
            pix_word[31 - 8*i -: 8] = lane_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
        end else begin
            if (accept) begin
                bus.m_valid <= 1'b1;
                bus.m_data  <= pix_word;
                x_cnt       <= bus.s_eol ? '0 : x_next;
                y_cnt       <= bus.s_eol ? y_next : y_use;
            end else if (bus.m_ready) begin
                bus.m_valid <= 1'b0;
            end
        end
    end

    // The datapath above reads the pre-edge table, so a same-cycle write only affects later beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_ok) begin
            tbl[tbl_index(cfg_y, cfg_x, cfg_lane)] <= cfg_wdata;
        end
    end

`ifdef UNDITHER_SATCOUNT_EN
    logic [15:0] sat_base;
    logic [16:0] sat_sum;

    assign sat_base = bus.s_sof ? '0 : sat_count;
    assign sat_sum  = {1'b0, sat_base} + 17'(clamp_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (accept) begin
            sat_count <= sat_sum[16] ? '1 : sat_sum[15:0];
        end
    end
`else
    logic unused_clamp;
    assign unused_clamp = ^clamp_cnt;
`endif

endmodule

// File: tb/tb_ordered_undithering.sv
// Self-checking bench for ordered_undithering: hand vectors, corner sequences and a
// randomized run against an arithmetic reference model with a transaction scoreboard.
module tb_ordered_undithering;
    localparam int BIAS = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [6:0] cfg_addr;
    logic [3:0] cfg_wdata;
`ifdef UNDITHER_SATCOUNT_EN
    logic [15:0] sat_count;
`endif

    ordered_undithering_if bus();

    ordered_undithering #(.COLORMODE("DES"), .BIAS(BIAS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
`ifdef UNDITHER_SATCOUNT_EN
        .sat_count (sat_count),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    int          tbl_m [6][3][4];
    int          mx, my, msat;
    bit          mv;
    logic [31:0] md;
    logic [31:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int c, input int b);
        int p;
        p = (c - b) * 16 + 8 - BIAS;
        if (p < 0)   return 8'h00;
        if (p > 255) return 8'hFF;
        return 8'(p);
    endfunction

    task automatic model_reset();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 3; x++)
                for (int l = 0; l < 4; l++)
                    tbl_m[y][x][l] = 0;
        mx = 0; my = 0; msat = 0; mv = 1'b0; md = '0;
        sb_q.delete();
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(bus.m_valid), 32'(mv));
        chk("m_data", bus.m_data, md);
`ifdef UNDITHER_SATCOUNT_EN
        chk("sat_count", 32'(sat_count), 32'(msat));
`endif
    endtask

    // Called just after a falling edge; returns one falling edge later.
    task automatic step(input bit v, input logic [15:0] d, input bit sof, input bit eol,
                        input bit rdy, input bit we, input logic [6:0] a, input logic [3:0] wd);
        bit acc;
        int xu, yu, c, b, p, ncl, wy, wx, wl;
        logic [31:0] word;
        bus.s_valid = v; bus.s_data = d; bus.s_sof = sof; bus.s_eol = eol;
        bus.m_ready = rdy;
        cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        #1;
        chk("s_ready", 32'(bus.s_ready), 32'(!mv || rdy));
        acc = v && (!mv || rdy);
        if (mv && rdy) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard: got delivery %h expected none", bus.m_data);
            end else begin
                chk("sb_word", bus.m_data, sb_q.pop_front());
            end
        end
        if (acc) begin
            xu = sof ? 0 : mx;
            yu = sof ? 0 : my;
            ncl = 0;
            word = '0;
            for (int i = 0; i < 4; i++) begin
                c = int'(d[15 - 4*i -: 4]);
                b = tbl_m[yu][xu][i];
                p = (c - b) * 16 + 8 - BIAS;
                if (p < 0 || p > 255) ncl++;
                word[31 - 8*i -: 8] = ref_pix(c, b);
            end
            md = word; mv = 1'b1;
            sb_q.push_back(word);
            msat = (sof ? 0 : msat) + ncl;
            if (msat > 65535) msat = 65535;
            if (eol) begin mx = 0; my = (yu + 1) % 6; end
            else     begin mx = (xu + 1) % 3; my = yu; end
        end else if (rdy) begin
            mv = 1'b0;
        end
        if (we) begin
            wy = int'(a[6:4]); wx = int'(a[3:2]); wl = int'(a[1:0]);
            if (wy < 6 && wx < 3) tbl_m[wy][wx][wl] = int'($signed(wd));
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        logic [15:0] data;
        bit          sof;
        bit          eol;
        bit          we;
        logic [6:0]  addr;
        logic [3:0]  wdata;
        logic [31:0] exp_data;
        int          exp_sat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          line, col;

        vecs[0]  = '{16'h08F0, 1'b1, 1'b0, 1'b0, 7'd0,  4'h0, 32'h007EEE00, 2};
        vecs[1]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 7'd0,  4'h8, 32'h00000000, 6};
        vecs[2]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 7'd3,  4'h7, 32'h00000000, 10};
        vecs[3]  = '{16'hF880, 1'b1, 1'b0, 1'b0, 7'd0,  4'h0, 32'hFF7E7E00, 2};
        vecs[4]  = '{16'hF880, 1'b0, 1'b0, 1'b1, 7'd4,  4'h1, 32'hEE7E7E00, 3};
        vecs[5]  = '{16'hF880, 1'b0, 1'b0, 1'b0, 7'd0,  4'h0, 32'hEE7E7E00, 4};
        vecs[6]  = '{16'hF880, 1'b0, 1'b0, 1'b0, 7'd0,  4'h0, 32'hFF7E7E00, 6};
        vecs[7]  = '{16'hF880, 1'b0, 1'b1, 1'b0, 7'd0,  4'h0, 32'hDE7E7E00, 7};
        vecs[8]  = '{16'h8888, 1'b0, 1'b0, 1'b0, 7'd0,  4'h0, 32'h7E7E7E7E, 7};
        vecs[9]  = '{16'h8888, 1'b0, 1'b0, 1'b0, 7'd0,  4'h0, 32'h7E7E7E7E, 7};
        vecs[10] = '{16'h8880, 1'b1, 1'b0, 1'b0, 7'd0,  4'h0, 32'hFE7E7E00, 1};
        vecs[11] = '{16'h8888, 1'b0, 1'b0, 1'b0, 7'd0,  4'h0, 32'h6E7E7E7E, 1};
        vecs[12] = '{16'h8888, 1'b1, 1'b1, 1'b0, 7'd0,  4'h0, 32'hFE7E7E0E, 0};
        vecs[13] = '{16'h8888, 1'b0, 1'b0, 1'b1, 7'd12, 4'h7, 32'h7E7E7E7E, 0};
        vecs[14] = '{16'h8888, 1'b0, 1'b1, 1'b0, 7'd0,  4'h0, 32'h7E7E7E7E, 0};
        vecs[15] = '{16'h8888, 1'b1, 1'b1, 1'b1, 7'd96, 4'h7, 32'hFE7E7E0E, 0};
        vecs[16] = '{16'h8888, 1'b0, 1'b0, 1'b0, 7'd0,  4'h0, 32'h7E7E7E7E, 0};

        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_sof = 1'b0; bus.s_eol = 1'b0;
        bus.m_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check_outputs();

        // Hand vectors: quantiser inverse, clamps, same-cycle writes, sof/eol corners
        for (int k = 0; k < 17; k++) begin
            step(1'b1, vecs[k].data, vecs[k].sof, vecs[k].eol, 1'b1,
                 vecs[k].we, vecs[k].addr, vecs[k].wdata);
            chk($sformatf("vec%0d_data", k), bus.m_data, vecs[k].exp_data);
`ifdef UNDITHER_SATCOUNT_EN
            chk($sformatf("vec%0d_sat", k), 32'(sat_count), 32'(vecs[k].exp_sat));
`endif
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

        // Backpressure: the first beat is taken, then the output must hold
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        held = bus.m_data;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            chk("hold_data", bus.m_data, held);
            chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
        end
        for (int k = 0; k < 20; k++)
            step(1'b1, 16'(32'h1111 * (k + 1) + 32'(k)), k == 0, (k % 3) == 2, 1'b1,
                 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Position pattern: table[y][x][0] = y + x, seven lines of three words
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 3; x++)
                step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, {3'(y), 2'(x), 2'd0}, 4'(y + x));
        for (int k = 0; k < 21; k++) begin
            line = k / 3;
            col  = k % 3;
            step(1'b1, 16'h8888, k == 0, col == 2, 1'b1, 1'b0, '0, '0);
            chk($sformatf("pattern_l%0d_x%0d", line, col), 32'(bus.m_data[31:24]),
                32'(126 - 16 * ((line % 6) + col)));
        end

        // Randomized traffic with random table updates (including out-of-range addresses)
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, 7'($urandom), 4'($urandom));

        // Asynchronous reset while a word is stalled at the output
        step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("async_rst_data", bus.m_data, 32'h0);
        chk("async_rst_s_ready", 32'(bus.s_ready), 32'd1);
`ifdef UNDITHER_SATCOUNT_EN
        chk("async_rst_sat", 32'(sat_count), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 16'h8888, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("post_rst_x0", bus.m_data, 32'h7E7E7E7E);
        step(1'b1, 16'h8888, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("post_rst_x1", bus.m_data, 32'h7E7E7E7E);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
